// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings, field widths and the stage payload.
package fpu_pkg;

  localparam int unsigned FOP_W  = 3;
  localparam int unsigned FREG_W = 5;

  localparam logic [FOP_W-1:0] FOP_ADD  = 3'b000;
  localparam logic [FOP_W-1:0] FOP_SUB  = 3'b001;
  localparam logic [FOP_W-1:0] FOP_MUL  = 3'b010;
  localparam logic [FOP_W-1:0] FOP_DIV  = 3'b100;
  localparam logic [FOP_W-1:0] FOP_SQRT = 3'b110;

  // One execute-stage slot: write valid, destination register, opcode.
  typedef struct packed {
    logic              w;
    logic [FREG_W-1:0] n;
    logic [FOP_W-1:0]  c;
  } stage_t;

  localparam stage_t STAGE_NULL = '0;

endpackage

// File: rtl/fpu_ds_cnt.sv
// Loadable down-counter that holds E1 while an fdiv/fsqrt iterates.
module fpu_ds_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic [CNT_W-1:0] lat,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear beats load; otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = lat;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/fpu_pipe_ctl.sv
// E1/E2/E3 tag pipeline for FP ops, with E1 hold while a div/sqrt iterates.
module fpu_pipe_ctl
  import fpu_pkg::*;
#(
  parameter int unsigned DIV_LAT  = 4,
  parameter int unsigned SQRT_LAT = 6,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              wf,
  input  logic [FOP_W-1:0]  fc,
  input  logic [FREG_W-1:0] fd,
  input  logic              fcancel,
  output logic [FREG_W-1:0] e1n,
  output logic [FREG_W-1:0] e2n,
  output logic [FREG_W-1:0] e3n,
  output logic              e1w,
  output logic              e2w,
  output logic              e3w,
  output logic [FOP_W-1:0]  e1c,
  output logic              stall_div_sqrt,
  output logic [CNT_W-1:0]  dcnt
);

  stage_t e1_q, e1_d;
  stage_t e2_q, e2_d;
  stage_t e3_q, e3_d;

  logic             busy;
  logic             cnt_load;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_lat;

  // Advance when the counter is idle; otherwise E1 holds and E2 takes a bubble.
  always_comb begin
    e1_d     = e1_q;
    e2_d     = e2_q;
    e3_d     = e2_q;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_lat  = fc[1] ? CNT_W'(SQRT_LAT) : CNT_W'(DIV_LAT);
    if (!busy) begin
      e1_d     = wf ? '{w: 1'b1, n: fd, c: fc} : STAGE_NULL;
      e2_d     = e1_q;
      e2_d.w   = e1_q.w & ~fcancel;
      cnt_load = wf & fc[2];
    end else begin
      // An op offered during a hold is a CU protocol error and is dropped.
      e2_d = STAGE_NULL;
      if (fcancel) begin
        e1_d.w  = 1'b0;
        cnt_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1_q <= STAGE_NULL;
      e2_q <= STAGE_NULL;
      e3_q <= STAGE_NULL;
    end else begin
      e1_q <= e1_d;
      e2_q <= e2_d;
      e3_q <= e3_d;
    end
  end

  fpu_ds_cnt #(
    .CNT_W (CNT_W)
  ) u_ds_cnt (
    .clk  (clk),
    .clrn (clrn),
    .load (cnt_load),
    .lat  (cnt_lat),
    .clr  (cnt_clr),
    .cnt  (dcnt),
    .busy (busy)
  );

  assign e1n            = e1_q.n;
  assign e2n            = e2_q.n;
  assign e3n            = e3_q.n;
  assign e1w            = e1_q.w;
  assign e2w            = e2_q.w;
  assign e3w            = e3_q.w;
  assign e1c            = e1_q.c;
  assign stall_div_sqrt = busy;

endmodule
